// File: rtl/debounce_multi_if.sv
// ============================================================================
// Module   : debounce_multi_if
// Brief    : Per-channel raw-input / debounced-status bundle for debounce_multi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface debounce_multi_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] bouncey_in;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] busy_out;
    logic [N_CH-1:0] rise_out;
    logic [N_CH-1:0] fall_out;

    modport master (
        output bouncey_in,
        input  clean_out,
        input  busy_out,
        input  rise_out,
        input  fall_out
    );

    modport slave (
        input  bouncey_in,
        output clean_out,
        output busy_out,
        output rise_out,
        output fall_out
    );
endinterface

`default_nettype wire

// File: rtl/debounce_multi.sv
// ============================================================================
// Module   : debounce_multi
// Brief    : N-channel switch debouncer, 2-flop sync + stability counter per
//            channel. Define DEBOUNCE_EDGE_EN for registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_multi #(
    parameter int   N_CH          = 4,
    parameter int   STABLE_CYCLES = 1_000_000,
    parameter logic RST_VAL       = 1'b0
) (
    input  wire logic       clk_in,
    input  wire logic       rst_in,
    debounce_multi_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("debounce_multi: STABLE_CYCLES must be >= 1");
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("debounce_multi: N_CH must be >= 1");
    end

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [N_CH-1:0] r_clean;
    logic [N_CH-1:0] w_commit;
    logic [N_CH-1:0] w_busy;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= {N_CH{RST_VAL}};
            r_sync2 <= {N_CH{RST_VAL}};
            r_clean <= {N_CH{RST_VAL}};
        end else begin
            r_sync1 <= bus.bouncey_in;
            r_sync2 <= r_sync1;
            // A commit only ever fires when sync differs from clean, so toggling is exact.
            r_clean <= r_clean ^ w_commit;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_diff;
        logic             w_commit_ch;

        assign w_diff = r_sync2[i] ^ r_clean[i];

        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_commit_ch = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_diff) begin
                        // With STABLE_CYCLES == 1 the limit is zero and the first mismatch commits.
                        if (r_cnt == c_CNT_MAX) begin
                            w_commit_ch = 1'b1;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_SETTLING;
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_SETTLING: begin
                    if (!w_diff) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        w_commit_ch = 1'b1;
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        assign w_commit[i] = w_commit_ch;
        assign w_busy[i]   = (r_cnt != '0);
    end

    assign bus.clean_out = r_clean;
    assign bus.busy_out  = w_busy;

`ifdef DEBOUNCE_EDGE_EN
    logic [N_CH-1:0] r_rise;
    logic [N_CH-1:0] r_fall;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_commit & r_sync2;
            r_fall <= w_commit & ~r_sync2;
        end
    end

    assign bus.rise_out = r_rise;
    assign bus.fall_out = r_fall;
`else
    assign bus.rise_out = '0;
    assign bus.fall_out = '0;
`endif

endmodule

`default_nettype wire
